// File: rtl/melody_sequencer.sv
// melody_sequencer: ROM-driven melody engine with start/stop/pause,
// loop, octave transpose, articulation gap and status strobes.

module melody_sequencer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BEAT_CYCLES = 30_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int DIV_W       = 18,
  parameter int DUR_W       = 3,
  parameter int ADDR_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic                    loop_en,
  input  logic [1:0]              octave_up,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DUR_W+DIV_W-1:0]  rom_data,
  output logic                    aud_pwm,
  output logic                    aud_sd,
  output logic                    busy,
  output logic                    note_strobe,
  output logic                    song_done
);

  if (CLK_HZ < 1 || BEAT_CYCLES < 2 ||
      GAP_CYCLES >= BEAT_CYCLES) begin : g_bad_cfg
    $error("melody_sequencer: bad timing parameters");
  end

  localparam int CNT_W = DUR_W + $clog2(BEAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BEAT = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] GAP  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   hp_q, hp_d;
  logic [DIV_W-1:0]   phase_q, phase_d;
  logic               pwm_q, pwm_d;

  logic [DUR_W-1:0]   rom_dur;
  logic [DIV_W-1:0]   rom_hp;
  logic [1:0]         oct_sh;
  logic               tone_on;

  assign {rom_dur, rom_hp} = rom_data;
  assign oct_sh = (octave_up == 2'd3) ? 2'd2 : octave_up;

  assign tone_on = (state_q == S_PLAY) && (cnt_q > GAP) &&
                   (hp_q != '0);

  assign rom_addr = addr_q;
  assign busy     = (state_q != S_IDLE);
  assign aud_sd   = busy;
  // pause mutes the pin in the same cycle it is seen
  assign aud_pwm  = pwm_q & tone_on & ~pause;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    hp_d        = hp_q;
    phase_d     = phase_q;
    pwm_d       = pwm_q;
    note_strobe = 1'b0;
    song_done   = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      cnt_d   = '0;
      hp_d    = '0;
      phase_d = '0;
      pwm_d   = 1'b0;
    end else if (start) begin
      state_d = S_FETCH;
      addr_d  = '0;
      cnt_d   = '0;
      phase_d = '0;
      pwm_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          addr_d = '0;
        end
        S_FETCH: begin
          state_d = S_LOAD;
        end
        S_LOAD: begin
          if (rom_dur == '0) begin
            addr_d = '0;
            if (loop_en) begin
              state_d = S_FETCH;
            end else begin
              song_done = 1'b1;
              state_d   = S_IDLE;
            end
          end else begin
            note_strobe = 1'b1;
            state_d     = S_PLAY;
            cnt_d       = CNT_W'(rom_dur) * BEAT;
            hp_d        = rom_hp >> oct_sh;
            phase_d     = '0;
            pwm_d       = 1'b0;
          end
        end
        S_PLAY: begin
          if (pause) begin
            pwm_d = 1'b0;
          end else begin
            cnt_d = cnt_q - ONE;
            if (tone_on) begin
              if (phase_q == hp_q - DIV_W'(1)) begin
                phase_d = '0;
                pwm_d   = ~pwm_q;
              end else begin
                phase_d = phase_q + DIV_W'(1);
              end
            end else begin
              phase_d = '0;
              pwm_d   = 1'b0;
            end
            if (cnt_q == ONE) begin
              phase_d = '0;
              pwm_d   = 1'b0;
              // last address wraps to 0 on increment
              addr_d  = addr_q + ADDR_W'(1);
              if (addr_q == LAST && !loop_en) begin
                song_done = 1'b1;
                state_d   = S_IDLE;
                addr_d    = '0;
              end else begin
                state_d = S_FETCH;
              end
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      hp_q    <= '0;
      phase_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: table-driven single-note vectors plus
// directed sequences for loop, wrap, pause, stop, restart and reset.

module tb_melody_sequencer;

  localparam int BEAT   = 20;
  localparam int GAP    = 4;
  localparam int DIV_W  = 8;
  localparam int DUR_W  = 3;
  localparam int ADDR_W = 3;
  localparam int W      = DUR_W + DIV_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic              loop_en = 1'b0;
  logic [1:0]        octave_up = 2'd0;
  logic [ADDR_W-1:0] rom_addr;
  logic [W-1:0]      rom_data;
  logic              aud_pwm;
  logic              aud_sd;
  logic              busy;
  logic              note_strobe;
  logic              song_done;

  logic [W-1:0]      rom [8];

  int nvec  = 0;
  int nbad  = 0;
  int ndone = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(negedge clk) if (song_done) ndone <= ndone + 1;

  melody_sequencer #(
    .CLK_HZ      (100_000_000),
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .DIV_W       (DIV_W),
    .DUR_W       (DUR_W),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .loop_en     (loop_en),
    .octave_up   (octave_up),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .aud_pwm     (aud_pwm),
    .aud_sd      (aud_sd),
    .busy        (busy),
    .note_strobe (note_strobe),
    .song_done   (song_done)
  );

  typedef struct {
    int dur;
    int hp;
    int oct;
    int len;
    int high;
    int rises;
    int first;
  } vec_t;

  vec_t tbl [9];

  function automatic int outs();
    return {23'd0, rom_addr, aud_pwm, aud_sd, busy,
            note_strobe, song_done};
  endfunction

  task automatic chk(input string name, input int got,
                     input int exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d",
               name, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic go_idle();
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_strobe(output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (note_strobe) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (song_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic load_two_notes();
    rom[0] = {3'd1, 8'd5};
    rom[1] = {3'd2, 8'd3};
    rom[2] = '0;
  endtask

  initial begin
    int n, s_t, d_t, high, rises, first, ns, d0, bad;
    logic prev;

    tbl[0] = '{1,  5, 0,  22,  6, 2,  6};
    tbl[1] = '{2,  0, 0,  42,  0, 0,  0};
    tbl[2] = '{1,  8, 1,  22,  8, 2,  5};
    tbl[3] = '{1,  8, 3,  22,  8, 4,  3};
    tbl[4] = '{1,  8, 2,  22,  8, 4,  3};
    tbl[5] = '{2,  3, 0,  42, 18, 6,  4};
    tbl[6] = '{1,  1, 0,  22,  8, 8,  2};
    tbl[7] = '{1,  3, 2,  22,  0, 0,  0};
    tbl[8] = '{7, 40, 0, 142, 56, 2, 41};

    for (int i = 0; i < 8; i++) rom[i] = '0;

    #1;
    chk("reset_outs", outs(), 0);
    step(3);
    rst_n = 1'b1;
    step(3);
    chk("idle_after_reset", outs(), 0);

    for (int i = 0; i < 9; i++) begin
      go_idle();
      rom[0] = {DUR_W'(tbl[i].dur), DIV_W'(tbl[i].hp)};
      rom[1] = '0;
      octave_up = 2'(tbl[i].oct);
      loop_en = 1'b0;
      s_t = -1; d_t = -1;
      high = 0; rises = 0; first = 0; ns = 0;
      prev = 1'b0;
      start = 1'b1;
      for (int t = 1; t <= 400 && d_t < 0; t++) begin
        @(negedge clk);
        start = 1'b0;
        if (note_strobe) begin
          ns++;
          if (s_t < 0) s_t = t;
        end
        if (aud_pwm) begin
          high++;
          if (!prev) rises++;
          if (first == 0 && s_t >= 0) first = t - s_t;
        end
        prev = aud_pwm;
        if (song_done) d_t = t;
      end
      chk($sformatf("v%0d_latency", i), s_t, 2);
      chk($sformatf("v%0d_len", i), d_t - s_t, tbl[i].len);
      chk($sformatf("v%0d_high", i), high, tbl[i].high);
      chk($sformatf("v%0d_rises", i), rises, tbl[i].rises);
      chk($sformatf("v%0d_first", i), first, tbl[i].first);
      chk($sformatf("v%0d_strobes", i), ns, 1);
      @(negedge clk);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
    end
    octave_up = 2'd0;

    // two notes, no loop
    go_idle();
    load_two_notes();
    d0 = ndone;
    start = 1'b1;
    wait_strobe(n);
    chk("two_first_strobe", n, 2);
    wait_strobe(n);
    chk("two_strobe_gap", n, 22);
    wait_done(n);
    chk("two_done_delay", n, 42);
    @(negedge clk);
    chk("two_after_done", {busy, aud_sd, song_done}, 0);
    chk("two_done_once", ndone - d0, 1);

    // same song looping: marker costs FETCH+LOAD
    go_idle();
    loop_en = 1'b1;
    d0 = ndone;
    start = 1'b1;
    wait_strobe(n);
    wait_strobe(n);
    wait_strobe(n);
    chk("loop_restrobe", n, 44);
    chk("loop_addr0", rom_addr, 0);
    chk("loop_no_done", ndone - d0, 0);

    // 8-word song without marker
    go_idle();
    for (int i = 0; i < 8; i++) rom[i] = {3'd1, 8'd2};
    start = 1'b1;
    wait_strobe(n);
    bad = 0;
    for (int j = 1; j <= 8; j++) begin
      wait_strobe(n);
      if (n != 22 || rom_addr != 3'(j)) bad++;
    end
    chk("wrap_loop_bad", bad, 0);
    chk("wrap_loop_addr0", rom_addr, 0);
    go_idle();
    loop_en = 1'b0;
    d0 = ndone;
    start = 1'b1;
    for (int j = 0; j < 8; j++) wait_strobe(n);
    chk("wrap_last_addr", rom_addr, 7);
    wait_done(n);
    chk("wrap_done_delay", n, 20);
    @(negedge clk);
    chk("wrap_busy_end", busy, 0);
    chk("wrap_done_once", ndone - d0, 1);

    // pause 7 cycles mid-note
    go_idle();
    load_two_notes();
    for (int i = 3; i < 8; i++) rom[i] = '0;
    start = 1'b1;
    wait_strobe(n);
    step(7);
    pause = 1'b1;
    bad = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (aud_pwm) bad++;
    end
    pause = 1'b0;
    chk("pause_pwm_low", bad, 0);
    @(negedge clk);
    chk("pause_resume_low", aud_pwm, 0);
    wait_strobe(n);
    chk("pause_strobe_gap", n + 15, 29);

    // stop during PLAY
    go_idle();
    d0 = ndone;
    start = 1'b1;
    wait_strobe(n);
    step(5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_outs", outs(), 0);
    step(30);
    chk("stop_still_idle", busy, 0);
    chk("stop_no_done", ndone - d0, 0);

    // restart during second note
    go_idle();
    start = 1'b1;
    wait_strobe(n);
    wait_strobe(n);
    step(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_fetch", {rom_addr, busy}, 1);
    wait_strobe(n);
    chk("restart_strobe", n, 1);
    chk("restart_addr", rom_addr, 0);

    // asynchronous reset mid-PLAY
    step(6);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    chk("rst_stays_idle", outs(), 0);
    start = 1'b1;
    wait_strobe(n);
    chk("rst_then_start", n, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
